// File: rtl/fifo_pkg.sv
// Shared types and helpers for the threshold FIFO family.
// Pointer and count arithmetic live here so every FIFO variant wraps identically.
package fifo_pkg;

   typedef struct packed {
      logic ovf;
      logic unf;
   } fifo_err_t;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Wrap at depth-1 so non-power-of-two depths never index a missing entry.
   function automatic int ptr_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_thr_if.sv
// Producer/consumer handshake and status bundle for sync_fifo_thr.
// master = the side driving push/pop, slave = the FIFO itself.
interface sync_fifo_thr_if #(
   parameter int data_w = 8,
   parameter int depth  = 4
);
   localparam int cw = fifo_pkg::cnt_w(depth);

   logic              push_i;
   logic [data_w-1:0] push_data_i;
   logic              pop_i;
   logic [data_w-1:0] pop_data_o;
   logic              clr_err_i;
   logic              e_o;
   logic              f_o;
   logic              ae_o;
   logic              af_o;
   logic [cw-1:0]     count_o;
   logic              ovf_o;
   logic              unf_o;

   modport master (
      output push_i, push_data_i, pop_i, clr_err_i,
      input  pop_data_o, e_o, f_o, ae_o, af_o, count_o, ovf_o, unf_o
   );

   modport slave (
      input  push_i, push_data_i, pop_i, clr_err_i,
      output pop_data_o, e_o, f_o, ae_o, af_o, count_o, ovf_o, unf_o
   );
endinterface

// File: rtl/fifo_mem.sv
// depth x data_w storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
   parameter int data_w = 8,
   parameter int depth  = 4,
   parameter int aw     = 2
) (
   input  logic              clock,
   input  logic              we,
   input  logic [aw-1:0]     waddr,
   input  logic [data_w-1:0] wdata,
   input  logic [aw-1:0]     raddr,
   output logic [data_w-1:0] rdata
);
   logic [data_w-1:0] mem [depth];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_thr.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module sync_fifo_thr
   import fifo_pkg::*;
#(
   parameter int data_w = 8,
   parameter int depth  = 4,
   parameter int af_thr = depth - 1,
   parameter int ae_thr = 1
) (
   input  logic      clock,
   input  logic      reset,
   sync_fifo_thr_if.slave bus
);
   localparam int cw = cnt_w(depth);
   localparam int pw = $clog2(depth);

   logic [pw-1:0]     wptr_q;
   logic [pw-1:0]     rptr_q;
   logic [cw-1:0]     count_q;
   logic [cw-1:0]     count_nxt;
   logic              push_acc;
   logic              pop_acc;
   fifo_err_t         err_q;
   fifo_err_t         err_nxt;
   logic              e_q;
   logic              f_q;
   logic              ae_q;
   logic              af_q;
   logic [data_w-1:0] rd_word;

   fifo_mem #(
      .data_w (data_w),
      .depth  (depth),
      .aw     (pw)
   ) u_mem (
      .clock (clock),
      .we    (push_acc),
      .waddr (wptr_q),
      .wdata (bus.push_data_i),
      .raddr (rptr_q),
      .rdata (rd_word)
   );

   // A pop on full frees a slot this cycle, so a same-cycle push may reuse it.
   always_comb begin
      push_acc  = bus.push_i && (!f_q || bus.pop_i);
      pop_acc   = bus.pop_i && !e_q;
      count_nxt = count_q;
      unique case ({push_acc, pop_acc})
         2'b10:   count_nxt = count_q + cw'(1);
         2'b01:   count_nxt = count_q - cw'(1);
         default: count_nxt = count_q;
      endcase
      err_nxt.ovf = (err_q.ovf && !bus.clr_err_i) || (bus.push_i && !push_acc);
      err_nxt.unf = (err_q.unf && !bus.clr_err_i) || (bus.pop_i && !pop_acc);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         err_q   <= '0;
         e_q     <= 1'b1;
         f_q     <= 1'b0;
         ae_q    <= 1'b1;
         af_q    <= 1'b0;
      end else begin
         if (push_acc) wptr_q <= pw'(ptr_inc(int'(wptr_q), depth));
         if (pop_acc)  rptr_q <= pw'(ptr_inc(int'(rptr_q), depth));
         count_q <= count_nxt;
         err_q   <= err_nxt;
         // Flags come from the next count so they line up with count_o.
         e_q     <= (count_nxt == '0);
         f_q     <= (count_nxt == cw'(depth));
         ae_q    <= (count_nxt <= cw'(ae_thr));
         af_q    <= (count_nxt >= cw'(af_thr));
      end
   end

`ifdef FIFO_FWFT_EN
   assign bus.pop_data_o = rd_word;
`else
   logic [data_w-1:0] rd_q;

   always_ff @(posedge clock) begin
      if (reset)        rd_q <= '0;
      else if (pop_acc) rd_q <= rd_word;
   end

   assign bus.pop_data_o = rd_q;
`endif

   assign bus.e_o     = e_q;
   assign bus.f_o     = f_q;
   assign bus.ae_o    = ae_q;
   assign bus.af_o    = af_q;
   assign bus.count_o = count_q;
   assign bus.ovf_o   = err_q.ovf;
   assign bus.unf_o   = err_q.unf;
endmodule

// File: tb/tb_sync_fifo_thr.sv
// Directed bench for sync_fifo_thr (data_w=8, depth=4, af_thr=3, ae_thr=1) with a queue scoreboard.
module tb_sync_fifo_thr;
   logic clock = 1'b0;
   logic reset = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [7:0] mq[$];
   logic [7:0] mdata;
   logic       movf;
   logic       munf;

   sync_fifo_thr_if #(.data_w(8), .depth(4)) bus ();

   sync_fifo_thr #(
      .data_w (8),
      .depth  (4),
      .af_thr (3),
      .ae_thr (1)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      int n;
      n = mq.size();
      check("count", 32'(bus.count_o), 32'(n));
      check("e_o",   32'(bus.e_o),  32'(n == 0));
      check("f_o",   32'(bus.f_o),  32'(n == 4));
      check("ae_o",  32'(bus.ae_o), 32'(n <= 1));
      check("af_o",  32'(bus.af_o), 32'(n >= 3));
      check("ovf_o", 32'(bus.ovf_o), 32'(movf));
      check("unf_o", 32'(bus.unf_o), 32'(munf));
`ifndef FIFO_FWFT_EN
      check("pop_data", 32'(bus.pop_data_o), 32'(mdata));
`endif
   endtask

   // Drives one cycle of stimulus, advances the model, then checks after the edge.
   task automatic step(input logic ps, input logic [7:0] d, input logic pp, input logic clr);
      logic pa, qa;
`ifdef FIFO_FWFT_EN
      if (mq.size() > 0) check("fwft_head", 32'(bus.pop_data_o), 32'(mq[0]));
`endif
      bus.push_i      = ps;
      bus.push_data_i = d;
      bus.pop_i       = pp;
      bus.clr_err_i   = clr;
      pa = ps && (mq.size() < 4 || pp);
      qa = pp && (mq.size() > 0);
      if (qa) mdata = mq.pop_front();
      if (pa) mq.push_back(d);
      movf = (movf && !clr) || (ps && !pa);
      munf = (munf && !clr) || (pp && !qa);
      @(posedge clock);
      #1;
      bus.push_i    = 1'b0;
      bus.pop_i     = 1'b0;
      bus.clr_err_i = 1'b0;
      check_state();
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      bus.push_i      = 1'b0;
      bus.push_data_i = 8'h00;
      bus.pop_i       = 1'b0;
      bus.clr_err_i   = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      mq.delete();
      mdata = 8'h00;
      movf  = 1'b0;
      munf  = 1'b0;
      check_state();
   endtask

   initial begin
      mdata = 8'h00;
      movf  = 1'b0;
      munf  = 1'b0;
      do_reset();
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 0);

      // two words through
      step(1, 8'hAB, 0, 0);
      step(1, 8'hCC, 0, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 1, 0);

      // fill, overflow, drain
      for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0);
      step(1, 8'h05, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 1);

      // underflow, clear, clear racing a new underflow
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 1, 1);
      step(0, 8'h00, 0, 1);

      // push with pop on empty: push taken, pop rejected
      step(1, 8'h55, 1, 0);
      step(0, 8'h00, 1, 1);

      // full-rate streaming across pointer wrap
      for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0, 0);
      for (int i = 0; i < 8; i++) step(1, 8'h10 + 8'(i), 1, 0);
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);

      // reset mid-stream
      for (int i = 0; i < 3; i++) step(1, 8'h60 + 8'(i), 0, 0);
      do_reset();
      step(1, 8'h77, 0, 0);
      step(0, 8'h00, 1, 0);
`ifndef FIFO_FWFT_EN
      check("first_after_reset", 32'(bus.pop_data_o), 32'h77);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sync_fifo_thr.md
# sync_fifo_thr

Parametrised synchronous FIFO and the successor to the basic push/pop FIFO. It adds programmable almost-full/almost-empty thresholds, a fill-level count, sticky overflow/underflow error flags and support for non-power-of-two depth. A compile-time first-word-fall-through read mode is also available. It sits between any producer/consumer pair in a single clock domain.

## Interface
- data_w, default 8: data word width in bits, ≥1.
- depth, default 4: number of entries, ≥2, any integer (no power-of-two restriction).
- af_thr, default depth-1: af_o asserts when count_o ≥ af_thr; legal range 1..depth.
- ae_thr, default 1: ae_o asserts when count_o ≤ ae_thr; legal range 0..depth-1.

Ports:
- clock  in  1: single clock, rising edge.
- reset  in  1: synchronous, active-high.
- push_i  in  1: write request.
- push_data_i  in  data_w: write data, sampled with push_i.
- pop_i  in  1: read request.
- pop_data_o  out  data_w: read data.
- clr_err_i  in  1: clears ovf_o and unf_o.
- e_o  out  1: empty (count_o == 0).
- f_o  out  1: full (count_o == depth).
- ae_o  out  1: almost empty.
- af_o  out  1: almost full.
- count_o  out  $clog2(depth+1): current number of stored entries.
- ovf_o  out  1: sticky overflow.
- unf_o  out  1: sticky underflow.

## Operation
- Accepted push: push_i && (!f_o || pop_i). The word is written at wptr, and wptr advances.
- Accepted pop: pop_i && !e_o. rptr advances.
- A push on an empty FIFO is accepted. A same-cycle pop is rejected, because the word is not yet readable.
- A push on a full FIFO with a same-cycle pop is accepted. count_o is unchanged and the freed slot is reused.
- A rejected push sets ovf_o; the data is dropped and the state is unchanged.
- A rejected pop sets unf_o; pointers are unchanged and pop_data_o holds its value.
- Pointers wrap from depth-1 to 0. They are compared through count_o, never through pointer MSB tricks.
- count_o changes by +1 (push only accepted), -1 (pop only accepted) or 0 (both or neither accepted).
- All flags are registered and derived from the next-state count, so they are valid in the same cycle count_o updates.
- ovf_o and unf_o stay set until clr_err_i is asserted or reset. If clr_err_i is asserted in the same cycle as a new error, the error wins and the flag stays set.
- Reset, including mid-operation, discards all contents and clears pointers, count and pop_data_o. Memory contents need not be cleared.

## Timing
- Values after reset deassertion: e_o=1, f_o=0, ae_o=1, af_o=0, count_o=0, pop_data_o=0, ovf_o=0, unf_o=0.
- Push-to-visible latency: a word pushed in cycle N makes e_o=0 in cycle N+1 and is poppable from cycle N+1.
- Default read mode: an accepted pop in cycle N presents the head word on pop_data_o from cycle N+1. The value holds until the next accepted pop.
- Full throughput: one push and one pop per cycle sustained, with no bubbles.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - pop_data_o shows the head entry combinationally whenever !e_o.
  - pop_i acknowledges and removes that word.
  - pop_data_o is don't-care while e_o=1.
  - All acceptance, count and flag rules are unchanged.
- FIFO_FWFT_EN undefined: registered read mode as described under Timing.

## Structure
- Shared package fifo_pkg:
  - fifo_err_t struct {ovf, unf}.
  - Pointer increment-with-wrap function ptr_inc(ptr, depth).
  - Count-width helper cnt_w(depth) = $clog2(depth+1).
- Sub-module fifo_mem: depth × data_w storage array.
  - One synchronous write port.
  - Read port is asynchronous; the top-level registers it when FIFO_FWFT_EN is undefined.
- The top level holds pointers, count, flags and error logic.

## Test plan
All scenarios use data_w=8, depth=4, af_thr=3, ae_thr=1.
- Reset then idle -> e_o=1, ae_o=1, f_o=0, af_o=0, count_o=0, pop_data_o=0x00, no errors.
- Push 0xAB, 0xCC, then pop twice -> count 1,2,1,0. pop_data_o reads 0xAB, then 0xCC one cycle after each pop (FWFT: 0xAB visible before the pop). e_o=1 at the end.
- Push 0x01..0x04, then push 0x05 -> af_o=1 at count 3, f_o=1 at count 4. 0x05 is dropped and ovf_o=1. Four pops return 0x01..0x04.
- Pop on empty -> unf_o=1 and count stays 0. clr_err_i pulse -> unf_o=0 next cycle. clr_err_i together with a new empty pop -> unf_o stays 1.
- Full FIFO with simultaneous push 0x10 and pop for 8 cycles -> count_o=4 throughout, ovf_o=0. Output sequence is correct across pointer wrap.
- Push three words, assert reset for one cycle mid-stream, then push 0x77 and pop -> post-reset flags match reset values, and 0x77 is the first word out.
